// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the ID stage: write-back select codes, immediate
// format codes, default datapath width and the immediate decoder.
package id_stage_pipe_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      RF_WSEL_ALUC = 2'd0,
      RF_WSEL_RDO  = 2'd1,
      RF_WSEL_PC4  = 2'd2,
      RF_WSEL_EXT  = 2'd3
   } rf_wsel_e;

   typedef enum logic [2:0] {
      SEXT_I = 3'd0,
      SEXT_S = 3'd1,
      SEXT_B = 3'd2,
      SEXT_U = 3'd3,
      SEXT_J = 3'd4
   } sext_op_e;

   // 32-bit immediate; the caller widens it to XLEN by sign extension.
   function automatic logic [31:0] sext32(input logic [2:0] op, input logic [31:7] ins);
      logic [31:0] imm;
      imm = '0;
      case (op)
         SEXT_I: imm = {{20{ins[31]}}, ins[31:20]};
         SEXT_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         SEXT_B: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         SEXT_U: imm = {ins[31:12], 12'd0};
         SEXT_J: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG-entry register file: two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero and a write-through bypass.
module id_regfile
   import id_stage_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wr,
   input  logic [XLEN-1:0] wd
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [5:0] NREG_L = 6'(NREG);

   logic [XLEN-1:0] mem [NREG];
   logic            ok1, ok2, okw;
   logic            wt1, wt2;

   // Index 0 and indices beyond the implemented file behave as constant zero.
   assign ok1 = (ra1 != '0) && ({1'b0, ra1} < NREG_L);
   assign ok2 = (ra2 != '0) && ({1'b0, ra2} < NREG_L);
   assign okw = (wr  != '0) && ({1'b0, wr}  < NREG_L);
   assign wt1 = we && (wr != '0) && (wr == ra1);
   assign wt2 = we && (wr != '0) && (wr == ra2);

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ok1) rd1 = wt1 ? wd : mem[ra1[AW-1:0]];
      if (ok2) rd2 = wt2 ? wd : mem[ra2[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '{default: '0};
      end else if (we && okw) begin
         mem[wr[AW-1:0]] <= wd;
      end
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: register file, immediate decode, write-back mux,
// RAW hazard detection and the ID/EX register. ID_FWD_EN enables the MEM bypass.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_inst,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   input  logic [2:0]      sext_op,
   input  logic            dec_rf_we,
   input  logic [1:0]      dec_rf_wsel,
   input  logic            dec_mem_read,
   input  logic            ex_ready,
   input  logic            flush,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rd1,
   output logic [XLEN-1:0] ex_rd2,
   output logic [XLEN-1:0] ex_ext,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_wr,
   output logic            ex_rf_we,
   output logic [1:0]      ex_rf_wsel,
   output logic            ex_mem_read,
   input  logic            mem_valid,
   input  logic            mem_we,
   input  logic [4:0]      mem_wr,
   input  logic [XLEN-1:0] mem_wd,
   input  logic            wb_we,
   input  logic [4:0]      wb_wr,
   input  logic [1:0]      wb_wsel,
   input  logic [XLEN-1:0] wb_aluc,
   input  logic [XLEN-1:0] wb_rdo,
   input  logic [XLEN-1:0] wb_pc4,
   input  logic [XLEN-1:0] wb_ext
);

   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] wb_wd, rf_rd1, rf_rd2, op1, op2, imm;
   logic [31:0]     imm32;
   logic            hz_ex, hm1, hm2, stall, accept;

   assign rs1 = if_inst[19:15];
   assign rs2 = if_inst[24:20];
   assign rd  = if_inst[11:7];

   always_comb begin
      wb_wd = wb_aluc;
      case (wb_wsel)
         RF_WSEL_ALUC: wb_wd = wb_aluc;
         RF_WSEL_RDO:  wb_wd = wb_rdo;
         RF_WSEL_PC4:  wb_wd = wb_pc4;
         RF_WSEL_EXT:  wb_wd = wb_ext;
         default:      wb_wd = wb_aluc;
      endcase
   end

   id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .ra2 (rs2),
      .rd1 (rf_rd1),
      .rd2 (rf_rd2),
      .we  (wb_we),
      .wr  (wb_wr),
      .wd  (wb_wd)
   );

   assign imm32 = sext32(sext_op, if_inst[31:7]);
   assign imm   = XLEN'($signed(imm32));

   // x0 never participates in a dependency.
   assign hz_ex = ex_valid & ex_rf_we &
                  (((rs1 != '0) & (ex_wr == rs1)) | ((rs2 != '0) & (ex_wr == rs2)));
   assign hm1   = mem_valid & mem_we & (rs1 != '0) & (mem_wr == rs1);
   assign hm2   = mem_valid & mem_we & (rs2 != '0) & (mem_wr == rs2);

`ifdef ID_FWD_EN
   assign op1   = hm1 ? mem_wd : rf_rd1;
   assign op2   = hm2 ? mem_wd : rf_rd2;
   assign stall = hz_ex & ex_mem_read;
`else
   assign op1   = rf_rd1;
   assign op2   = rf_rd2;
   assign stall = hz_ex | hm1 | hm2;
`endif

   assign id_ready = ~rst & ~stall & (ex_ready | ~ex_valid);
   assign accept   = id_ready & if_valid;

   // Flush only drops the valid bit; payload holds, matching the priority order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_ext      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_wr       <= '0;
         ex_rf_we    <= 1'b0;
         ex_rf_wsel  <= '0;
         ex_mem_read <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid    <= 1'b1;
         ex_pc       <= if_pc;
         ex_rd1      <= op1;
         ex_rd2      <= op2;
         ex_ext      <= imm;
         ex_rs1      <= rs1;
         ex_rs2      <= rs2;
         ex_wr       <= rd;
         ex_rf_we    <= dec_rf_we;
         ex_rf_wsel  <= dec_rf_wsel;
         ex_mem_read <= dec_mem_read;
      end else if (stall && (ex_ready || !ex_valid)) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: decode vectors from a table, scoreboarded ID/EX
// entries, and hand-written hazard, back-pressure, flush and reset sequences.
module tb_id_stage_pipe;

   localparam int XLEN = 32;

`ifdef ID_FWD_EN
   localparam int LU_BUBBLES  = 1;
   localparam int MEM_BUBBLES = 0;
`else
   localparam int LU_BUBBLES  = 2;
   localparam int MEM_BUBBLES = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            if_valid;
   logic [31:0]     if_inst;
   logic [XLEN-1:0] if_pc;
   logic            id_ready;
   logic [2:0]      sext_op;
   logic            dec_rf_we;
   logic [1:0]      dec_rf_wsel;
   logic            dec_mem_read;
   logic            ex_ready;
   logic            flush;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_ext;
   logic [4:0]      ex_rs1, ex_rs2, ex_wr;
   logic            ex_rf_we;
   logic [1:0]      ex_rf_wsel;
   logic            ex_mem_read;
   logic            mem_valid, mem_we;
   logic [4:0]      mem_wr;
   logic [XLEN-1:0] mem_wd;
   logic            wb_we;
   logic [4:0]      wb_wr;
   logic [1:0]      wb_wsel;
   logic [XLEN-1:0] wb_aluc, wb_rdo, wb_pc4, wb_ext;

   id_stage_pipe #(.XLEN(XLEN), .NREG(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_inst      (if_inst),
      .if_pc        (if_pc),
      .id_ready     (id_ready),
      .sext_op      (sext_op),
      .dec_rf_we    (dec_rf_we),
      .dec_rf_wsel  (dec_rf_wsel),
      .dec_mem_read (dec_mem_read),
      .ex_ready     (ex_ready),
      .flush        (flush),
      .ex_valid     (ex_valid),
      .ex_pc        (ex_pc),
      .ex_rd1       (ex_rd1),
      .ex_rd2       (ex_rd2),
      .ex_ext       (ex_ext),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_wr        (ex_wr),
      .ex_rf_we     (ex_rf_we),
      .ex_rf_wsel   (ex_rf_wsel),
      .ex_mem_read  (ex_mem_read),
      .mem_valid    (mem_valid),
      .mem_we       (mem_we),
      .mem_wr       (mem_wr),
      .mem_wd       (mem_wd),
      .wb_we        (wb_we),
      .wb_wr        (wb_wr),
      .wb_wsel      (wb_wsel),
      .wb_aluc      (wb_aluc),
      .wb_rdo       (wb_rdo),
      .wb_pc4       (wb_pc4),
      .wb_ext       (wb_ext)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, rd1, rd2, ext;
      logic [4:0]  rs1, rs2, wr;
      logic        rf_we;
      logic [1:0]  wsel;
      logic        mr;
   } ent_t;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  sop;
      logic [1:0]  wsel;
      logic        mr;
      logic [31:0] rd1, rd2, ext;
   } vec_t;

   ent_t exp_q[$];
   vec_t vt[8];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      if_valid  = 1'b0;
      flush     = 1'b0;
      ex_ready  = 1'b1;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_wr    = '0;
      mem_wd    = '0;
      wb_we     = 1'b0;
      wb_wr     = '0;
      wb_wsel   = '0;
      wb_aluc   = '0;
      wb_rdo    = '0;
      wb_pc4    = '0;
      wb_ext    = '0;
   endtask

   task automatic wb_set(input logic [4:0] wr, input logic [1:0] wsel, input logic [31:0] val);
      wb_we   = 1'b1;
      wb_wr   = wr;
      wb_wsel = wsel;
      wb_aluc = (wsel == 2'd0) ? val : 32'hA0A0_A0A0;
      wb_rdo  = (wsel == 2'd1) ? val : 32'hB1B1_B1B1;
      wb_pc4  = (wsel == 2'd2) ? val : 32'hC2C2_C2C2;
      wb_ext  = (wsel == 2'd3) ? val : 32'hD3D3_D3D3;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [2:0] sop,
                        input logic we, input logic [1:0] wsel, input logic mr);
      if_valid     = 1'b1;
      if_inst      = inst;
      if_pc        = pc;
      sext_op      = sop;
      dec_rf_we    = we;
      dec_rf_wsel  = wsel;
      dec_mem_read = mr;
   endtask

   task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rd1,
                           input logic [31:0] rd2, input logic [31:0] ext, input logic we,
                           input logic [1:0] wsel, input logic mr);
      ent_t e;
      e.pc = pc;  e.rd1 = rd1;  e.rd2 = rd2;  e.ext = ext;
      e.rs1 = inst[19:15];  e.rs2 = inst[24:20];  e.wr = inst[11:7];
      e.rf_we = we;  e.wsel = wsel;  e.mr = mr;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input string nm);
      ent_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got ex_valid=%0b, required a queued entry", nm, ex_valid);
      end else begin
         e = exp_q.pop_front();
         chk({nm, ".valid"}, ex_valid, 1);
         chk({nm, ".pc"},    ex_pc,    e.pc);
         chk({nm, ".rd1"},   ex_rd1,   e.rd1);
         chk({nm, ".rd2"},   ex_rd2,   e.rd2);
         chk({nm, ".ext"},   ex_ext,   e.ext);
         chk({nm, ".idx"},   {ex_rs1, ex_rs2, ex_wr}, {e.rs1, e.rs2, e.wr});
         chk({nm, ".ctl"},   {ex_rf_we, ex_rf_wsel, ex_mem_read}, {e.rf_we, e.wsel, e.mr});
      end
   endtask

   task automatic do_flush(input string nm);
      if_valid = 1'b0;
      flush    = 1'b1;
      step();
      flush = 1'b0;
      chk({nm, ".flush_valid"}, ex_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bubbles;
      bit accepted;

      vt[0] = '{32'hFFF0_8293, 3'd0, 2'd0, 1'b0, 32'h1111_1111, 32'h0,         32'hFFFF_FFFF};
      vt[1] = '{32'hFE21_AE23, 3'd1, 2'd1, 1'b1, 32'h3333_3333, 32'h2222_2222, 32'hFFFF_FFFC};
      vt[2] = '{32'hFE00_0EE3, 3'd2, 2'd2, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC};
      vt[3] = '{32'h1234_53B7, 3'd3, 2'd3, 1'b0, 32'h0,         32'h3333_3333, 32'h1234_5000};
      vt[4] = '{32'h0010_04EF, 3'd4, 2'd2, 1'b0, 32'h0,         32'h1111_1111, 32'h0000_0800};
      vt[5] = '{32'hFFFF_F06F, 3'd4, 2'd2, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFE};
      vt[6] = '{32'hFFFF_FFFF, 3'd7, 2'd0, 1'b0, 32'h0,         32'h0,         32'h0};
      vt[7] = '{32'h0022_0333, 3'd0, 2'd0, 1'b0, 32'h4444_4444, 32'h2222_2222, 32'h0000_0002};

      // Reset held two cycles with an instruction reading x5 presented.
      idle();
      rst = 1'b1;
      drive(32'h0002_8333, 32'h100, 3'd0, 1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst.id_ready", id_ready, 0);
         chk("rst.ex_valid", ex_valid, 0);
         chk("rst.ex_rd1",   ex_rd1,   0);
         chk("rst.ex_pc",    ex_pc,    0);
      end
      rst = 1'b0;

      // Same-cycle write-back of x5 is seen by the reader.
      wb_set(5'd5, 2'd1, 32'hDEAD_BEEF);
      push_exp(32'h0002_8333, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
      settle();
      chk("wt.id_ready", id_ready, 1);
      step();
      wb_we = 1'b0;
      pop_cmp("wt");
      drive(32'h0002_8333, 32'h104, 3'd0, 1'b0, 2'd0, 1'b0);
      push_exp(32'h0002_8333, 32'h104, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
      step();
      pop_cmp("rf5");

      // x0 ignores writes, both through the bypass and from the array.
      wb_set(5'd0, 2'd0, 32'h1234);
      drive(32'h0000_04B3, 32'h108, 3'd0, 1'b0, 2'd0, 1'b0);
      push_exp(32'h0000_04B3, 32'h108, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
      step();
      wb_we = 1'b0;
      pop_cmp("x0wt");
      drive(32'h0000_04B3, 32'h10C, 3'd0, 1'b0, 2'd0, 1'b0);
      push_exp(32'h0000_04B3, 32'h10C, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
      step();
      pop_cmp("x0rf");

      // Populate x1..x4 through each write-back select code.
      if_valid = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         wb_set(5'(i + 1), 2'(i), 32'h1111_1111 * (i + 1));
         step();
      end
      wb_we = 1'b0;

      for (int i = 0; i < 8; i++) begin
         drive(vt[i].inst, 32'h1000 + 4 * i, vt[i].sop, 1'b0, vt[i].wsel, vt[i].mr);
         push_exp(vt[i].inst, 32'h1000 + 4 * i, vt[i].rd1, vt[i].rd2, vt[i].ext, 1'b0,
                  vt[i].wsel, vt[i].mr);
         settle();
         chk($sformatf("vec%0d.id_ready", i), id_ready, 1);
         step();
         pop_cmp($sformatf("vec%0d", i));
      end
      do_flush("vec");

      // Load-use: lw x3 then add x4,x3,x1; lw walks through MEM then WB.
      drive(32'h0000_A183, 32'h200, 3'd0, 1'b1, 2'd1, 1'b1);
      push_exp(32'h0000_A183, 32'h200, 32'h1111_1111, 32'h0, 32'h0, 1'b1, 2'd1, 1'b1);
      settle();
      chk("lw.id_ready", id_ready, 1);
      step();
      pop_cmp("lw");
      drive(32'h0011_8233, 32'h204, 3'd0, 1'b1, 2'd0, 1'b0);
      push_exp(32'h0011_8233, 32'h204, 32'h5A5A_0003, 32'h1111_1111, 32'h1, 1'b1, 2'd0, 1'b0);
      bubbles = 0;
      accepted = 1'b0;
      for (int c = 0; c < 5 && !accepted; c++) begin
         if (c == 1) begin
            mem_valid = 1'b1; mem_we = 1'b1; mem_wr = 5'd3; mem_wd = 32'h5A5A_0003;
         end
         if (c == 2) wb_set(5'd3, 2'd1, 32'h5A5A_0003);
         settle();
         if (id_ready) accepted = 1'b1;
         else bubbles++;
         step();
         if (!accepted) chk("lu.bubble_valid", ex_valid, 0);
         mem_valid = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
      end
      chk("lu.issued", accepted, 1);
      chk("lu.bubbles", bubbles, LU_BUBBLES);
      pop_cmp("lu.add");
      do_flush("lu");

      // MEM-stage producer of x7 while the RF still holds the old value.
      wb_set(5'd7, 2'd0, 32'h11);
      step();
      wb_we = 1'b0;
      drive(32'h0003_8433, 32'h300, 3'd0, 1'b0, 2'd0, 1'b0);
      push_exp(32'h0003_8433, 32'h300, 32'h55, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
      bubbles = 0;
      accepted = 1'b0;
      for (int c = 0; c < 4 && !accepted; c++) begin
         if (c == 0) begin
            mem_valid = 1'b1; mem_we = 1'b1; mem_wr = 5'd7; mem_wd = 32'h55;
         end
         if (c == 1) wb_set(5'd7, 2'd0, 32'h55);
         settle();
         if (id_ready) accepted = 1'b1;
         else bubbles++;
         step();
         mem_valid = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
      end
      chk("mb.issued", accepted, 1);
      chk("mb.bubbles", bubbles, MEM_BUBBLES);
      pop_cmp("mb.add");
      do_flush("mb");

      // Back-pressure for three cycles, then flush together with a fetch.
      drive(32'h0022_0333, 32'h400, 3'd0, 1'b0, 2'd0, 1'b0);
      push_exp(32'h0022_0333, 32'h400, 32'h4444_4444, 32'h2222_2222, 32'h2, 1'b0, 2'd0, 1'b0);
      step();
      pop_cmp("bp.a");
      ex_ready = 1'b0;
      drive(32'h0002_8333, 32'h404, 3'd0, 1'b0, 2'd0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("bp.id_ready", id_ready, 0);
         step();
         chk("bp.valid", ex_valid, 1);
         chk("bp.pc",    ex_pc,    32'h400);
         chk("bp.rd1",   ex_rd1,   32'h4444_4444);
      end
      ex_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      if_valid = 1'b0;
      chk("fl.valid", ex_valid, 0);
      chk("fl.pc",    ex_pc,    32'h400);

      // Reset during a load-use stall clears ID/EX and the register file.
      drive(32'h0000_A183, 32'h500, 3'd0, 1'b1, 2'd1, 1'b1);
      push_exp(32'h0000_A183, 32'h500, 32'h1111_1111, 32'h0, 32'h0, 1'b1, 2'd1, 1'b1);
      step();
      pop_cmp("rs.lw");
      drive(32'h0011_8233, 32'h504, 3'd0, 1'b1, 2'd0, 1'b0);
      settle();
      chk("rs.stall", id_ready, 0);
      rst = 1'b1;
      step();
      chk("rs.id_ready", id_ready, 0);
      chk("rs.valid",    ex_valid, 0);
      chk("rs.pc",       ex_pc,    0);
      chk("rs.wr_ctl",   {ex_wr, ex_rf_we, ex_mem_read}, 0);
      rst = 1'b0;
      drive(32'h0020_8333, 32'h600, 3'd0, 1'b0, 2'd0, 1'b0);
      push_exp(32'h0020_8333, 32'h600, 32'h0, 32'h0, 32'h2, 1'b0, 2'd0, 1'b0);
      step();
      pop_cmp("rs.rf_clear");

      chk("sb.empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised pipelined instruction-decode stage for the five-stage miniCPU. It holds the NREG-entry register file with a write-through bypass, the immediate sign-extender and the write-back data multiplexer. It registers decoded operands into an ID/EX pipeline register with a valid/ready handshake. It detects RAW hazards and inserts a bubble when the hazard cannot be resolved by forwarding.

## Interface
- XLEN, 32: datapath width, ≥32.
- NREG, 32: architectural register count; 16 (RV32E) or 32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF/ID holds an instruction.
- if_inst  in  32  instruction word.
- if_pc  in  XLEN  PC of if_inst.
- id_ready  out  1  ID accepts if_inst this cycle.
- sext_op  in  3  immediate format from controller.
- dec_rf_we, dec_rf_wsel[1:0], dec_mem_read  in  1/2/1  controller decode for if_inst.
- ex_ready  in  1  EX accepts the ID/EX entry.
- flush  in  1  kill the ID/EX entry (taken branch/jump).
- ex_valid  out  1  ID/EX entry valid.
- ex_pc, ex_rd1, ex_rd2, ex_ext  out  XLEN  registered PC, operands and immediate.
- ex_rs1, ex_rs2, ex_wr  out  5  registered source and destination indices.
- ex_rf_we, ex_rf_wsel[1:0], ex_mem_read  out  registered controls.
- mem_valid, mem_we  in  1  MEM-stage entry valid and writes the register file.
- mem_wr  in  5  MEM-stage destination index.
- mem_wd  in  XLEN  MEM-stage result.
- wb_we  in  1  write-back enable.
- wb_wr  in  5  write-back destination index.
- wb_wsel  in  2  write-back data select.
- wb_aluc, wb_rdo, wb_pc4, wb_ext  in  XLEN  write-back candidates.

## Operation
- Write-back mux:
  - wb_wsel selects wb_aluc, wb_rdo, wb_pc4 or wb_ext, using the RF_WSEL_ALUC/RDO/PC4/EXT codes.
  - Any other code selects wb_aluc.
- Register file:
  - Two asynchronous read ports and one synchronous write port, NREG entries.
  - x0 reads 0 and ignores writes.
  - Indices ≥ NREG read 0 and are ignored on write.
  - Write-through: a read of wb_wr while wb_we=1 and wb_wr≠0 returns the write-back data in the same cycle.
- SEXT: decodes the I, S, B, U and J immediate formats from if_inst[31:7] to XLEN bits. An undefined op gives 0.
- Hazard detection:
  - A source register rs counts as "used" when it is non-zero. The decoder passes all fields; rs2 is compared unconditionally.
  - hazard_ex = ex_valid & ex_rf_we & (ex_wr == rs).
  - hazard_mem = mem_valid & mem_we & (mem_wr == rs).
- stall is defined by the configuration; see ## Configuration.
- id_ready = ~rst & ~stall & (ex_ready | ~ex_valid).
- ID/EX register update rule, in priority order:
  1. rst: clear the register.
  2. flush: set ex_valid to 0.
  3. id_ready & if_valid: load the new entry.
  4. stall & (ex_ready | ~ex_valid): set ex_valid to 0 (bubble).
  5. Otherwise: hold.

## Timing
- Reset: every ex_* output is 0, ex_valid is 0, id_ready is 0 during rst, and every RF entry is 0.
- Latency: an instruction accepted at edge N appears on ex_* after edge N.
- A register-file write at edge N is visible on the read ports immediately, through the write-through bypass, and from the array after edge N.
- Simultaneous flush and accept: flush wins. The fetched instruction is dropped; IF discards it on flush.
- Back-pressure: while ex_valid=1 and ex_ready=0, every ex_* output holds and id_ready is 0.
- Reset asserted mid-stall: the ID/EX register clears on the next edge. There is no replay.

## Configuration
- ID_FWD_EN defined:
  - MEM-stage bypass into rd1/rd2 when hazard_mem (mem_wd has priority over the RF read).
  - stall = hazard_ex & ex_mem_read (load-use only: one bubble).
  - Non-load EX hazards are resolved downstream in EX using ex_rs1/ex_rs2.
- ID_FWD_EN undefined:
  - No MEM bypass.
  - stall = hazard_ex | hazard_mem. A dependent instruction waits for the producer to reach WB (up to two bubbles).

## Structure
- Shared defines header: RF_WSEL_* codes, SEXT_I/S/B/U/J codes, default XLEN.
- Sub-module id_regfile: RF array, reset, x0 and bound rules, write-through bypass.
- SEXT, the write-back mux, hazard logic and the ID/EX register live in id_stage_pipe.

## Test plan
- **Reset and WB mux:** Hold rst for 2 cycles, then read x5. Expect rd1=0, ex_valid=0 and id_ready=0 while rst is high. Then write x5 with wb_wsel=RDO and wb_rdo=0xDEADBEEF. Expect an instruction reading x5 in the same cycle to see 0xDEADBEEF.
- **x0:** wb_we=1, wb_wr=0, wb_aluc=0x1234. Then read x0. Expect 0.
- **Load-use with ID_FWD_EN:** lw x3 in ID/EX (ex_mem_read=1), add x4,x3,x1 in ID. Expect exactly one bubble (ex_valid=0 for one cycle), then add issues.
- **MEM bypass:**
  - With ID_FWD_EN: mem_wr=7, mem_wd=0x55, RF x7=0x11. Expect ex_rd1=0x55 with no stall.
  - Without ID_FWD_EN: expect stall until x7 is written back.
- **Back-pressure and flush:** Hold ex_ready=0 for 3 cycles. Expect ex_* stable and id_ready=0. Assert flush together with if_valid. Expect ex_valid=0 next cycle.
- **SEXT:** B-type inst 0xFE000EE3. Expect ex_ext=0xFFFFFFFC.
